// File: rtl/fighter_motion_pkg.sv
// Shared types for the fighter motion controller: FSM states, blitter pose codes,
// HID keycodes and the X clamp helper.
package fighter_motion_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_JUMP  = 3'd2,
        ST_PUNCH = 3'd3,
        ST_KICK  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        POSE_STAND  = 3'd0,
        POSE_RUN1   = 3'd1,
        POSE_RUN2   = 3'd2,
        POSE_FIGHT  = 3'd3,
        POSE_FIGHT1 = 3'd4,
        POSE_KICK1  = 3'd5,
        POSE_KICK2  = 3'd6
    } pose_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_J = 8'h0D;
    localparam logic [7:0] KEY_K = 8'h0E;

    // Saturate a signed candidate X into the legal on-screen range [0, xmax].
    function automatic logic [9:0] clamp_x(input logic signed [10:0] v,
                                           input logic signed [10:0] xmax);
        logic [9:0] r;
        if (v < 11'sd0)
            r = 10'd0;
        else if (v > xmax)
            r = xmax[9:0];
        else
            r = v[9:0];
        return r;
    endfunction

endpackage

// File: rtl/fighter_motion_if.sv
// Keycode in, sprite position/pose out; master is the keyboard/blitter side,
// slave is the motion controller.
interface fighter_motion_if;
    logic [7:0] keycode;
    logic [9:0] positionX;
    logic [9:0] positionY;
    logic [2:0] status;
    logic       facing;

    modport master (
        output keycode,
        input  positionX,
        input  positionY,
        input  status,
        input  facing
    );

    modport slave (
        input  keycode,
        output positionX,
        output positionY,
        output status,
        output facing
    );
endinterface

// File: rtl/fighter_motion_frame_tick_gen.sv
// Brings the vsync-rate frame_clk into the Clk domain and emits a one-cycle
// frame_tick on each rising edge.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);
    localparam int STAGES = 3;

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            sync_reg[0] <= 1'b0;
        else
            sync_reg[0] <= frame_clk;
    end

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_sync
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n)
                    sync_reg[gi] <= 1'b0;
                else
                    sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    // Stage 1 is the settled synchronised level; stage 2 is its previous value.
    assign frame_tick = sync_reg[1] & ~sync_reg[2];
endmodule

// File: rtl/fighter_motion.sv
// Per-frame fighter motion/pose FSM. Optional FIGHTER_FACING_EN makes `facing`
// follow the last horizontal run direction; otherwise it is tied low.
module fighter_motion
    import fighter_motion_pkg::*;
#(
    parameter int X_START     = 100,
    parameter int X_MAX       = 539,
    parameter int GROUND_Y    = 300,
    parameter int STEP        = 4,
    parameter int JUMP_V0     = 12,
    parameter int KICK_FRAMES = 8,
    parameter int RUN_PERIOD  = 6
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_clk,
    fighter_motion_if.slave  bus
);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
    localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
    localparam logic signed [7:0]  JUMP_V0_S = 8'(JUMP_V0);
    localparam logic [7:0]         ATK_LEN  = 8'(KICK_FRAMES);
    localparam logic [7:0]         ATK_HALF = 8'(KICK_FRAMES / 2);
    localparam logic [7:0]         RUN_LEN  = 8'(RUN_PERIOD);

    logic frame_tick;

    frame_tick_gen u_frame_tick_gen (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    state_t            state_reg;
    pose_t             pose_reg;
    logic [9:0]        x_reg;
    logic [9:0]        y_reg;
    logic signed [7:0] vy_reg;
    logic [7:0]        run_cnt_reg;
    logic [7:0]        atk_cnt_reg;
`ifdef FIGHTER_FACING_EN
    logic              facing_reg;
`endif

    logic [7:0]         key;
    logic               move_left;
    logic               move_right;
    logic signed [10:0] x_wide;
    logic signed [10:0] x_step;
    logic [9:0]         x_next;
    logic signed [7:0]  vy_src;
    logic signed [7:0]  vy_next;
    logic signed [10:0] y_next;
    logic               landed;
    logic [7:0]         atk_next;
    pose_t              atk_pose;

    always_comb begin
        key        = bus.keycode;
        move_left  = (key == KEY_A);
        move_right = (key == KEY_D);

        x_wide = signed'({1'b0, x_reg});
        x_step = x_wide;
        if (move_left)
            x_step = x_wide - STEP_S;
        else if (move_right)
            x_step = x_wide + STEP_S;
        x_next = clamp_x(x_step, XMAX_S);

        // Jump launch uses the initial velocity directly so the take-off tick already rises.
        vy_src  = (state_reg == ST_JUMP) ? vy_reg : JUMP_V0_S;
        vy_next = vy_src - 8'sd1;
        y_next  = signed'({1'b0, y_reg}) - {{3{vy_src[7]}}, vy_src};
        landed  = (y_next >= GROUND_S);

        atk_next = atk_cnt_reg + 8'd1;
        if (state_reg == ST_KICK)
            atk_pose = (atk_next <= ATK_HALF) ? POSE_KICK1 : POSE_KICK2;
        else
            atk_pose = (atk_next <= ATK_HALF) ? POSE_FIGHT : POSE_FIGHT1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg   <= ST_IDLE;
            pose_reg    <= POSE_STAND;
            x_reg       <= 10'(X_START);
            y_reg       <= 10'(GROUND_Y);
            vy_reg      <= 8'sd0;
            run_cnt_reg <= 8'd0;
            atk_cnt_reg <= 8'd0;
`ifdef FIGHTER_FACING_EN
            facing_reg  <= 1'b0;
`endif
        end else if (frame_tick) begin
            case (state_reg)
                ST_IDLE, ST_RUN: begin
                    if (key == KEY_K) begin
                        state_reg   <= ST_KICK;
                        atk_cnt_reg <= 8'd1;
                        pose_reg    <= POSE_KICK1;
                    end else if (key == KEY_J) begin
                        state_reg   <= ST_PUNCH;
                        atk_cnt_reg <= 8'd1;
                        pose_reg    <= POSE_FIGHT;
                    end else if (key == KEY_W) begin
                        state_reg <= ST_JUMP;
                        y_reg     <= y_next[9:0];
                        vy_reg    <= vy_next;
                        pose_reg  <= POSE_STAND;
                    end else if (move_left || move_right) begin
                        state_reg <= ST_RUN;
                        x_reg     <= x_next;
`ifdef FIGHTER_FACING_EN
                        facing_reg <= move_left;
`endif
                        if (state_reg != ST_RUN) begin
                            run_cnt_reg <= 8'd1;
                            pose_reg    <= POSE_RUN1;
                        end else if (run_cnt_reg >= RUN_LEN) begin
                            run_cnt_reg <= 8'd1;
                            pose_reg    <= (pose_reg == POSE_RUN1) ? POSE_RUN2 : POSE_RUN1;
                        end else begin
                            run_cnt_reg <= run_cnt_reg + 8'd1;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                        pose_reg  <= POSE_STAND;
                    end
                end
                ST_JUMP: begin
                    x_reg    <= x_next;
                    pose_reg <= POSE_STAND;
                    if (landed) begin
                        y_reg     <= 10'(GROUND_Y);
                        vy_reg    <= 8'sd0;
                        state_reg <= ST_IDLE;
                    end else begin
                        y_reg  <= y_next[9:0];
                        vy_reg <= vy_next;
                    end
                end
                ST_PUNCH, ST_KICK: begin
                    if (atk_cnt_reg >= ATK_LEN) begin
                        state_reg   <= ST_IDLE;
                        atk_cnt_reg <= 8'd0;
                        pose_reg    <= POSE_STAND;
                    end else begin
                        atk_cnt_reg <= atk_next;
                        pose_reg    <= atk_pose;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    pose_reg  <= POSE_STAND;
                end
            endcase
        end
    end

    assign bus.positionX = x_reg;
    assign bus.positionY = y_reg;
    assign bus.status    = pose_reg;
`ifdef FIGHTER_FACING_EN
    assign bus.facing    = facing_reg;
`else
    assign bus.facing    = 1'b0;
`endif
endmodule

// File: tb/tb_fighter_motion.sv
// Frame-level bench for fighter_motion: directed scenarios with hand-derived
// values plus randomized key streams against an integer reference model.
module tb_fighter_motion;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic frame_clk = 1'b0;

    fighter_motion_if bus ();

    fighter_motion dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_frame  = 0;

    // Reference model: plain integers; mode 0 idle, 1 run, 2 jump, 3 punch, 4 kick.
    int m_x, m_y, m_vy, m_mode, m_run, m_atk, m_status, m_face;

    function automatic int clampx(input int v);
        if (v < 0) return 0;
        if (v > 539) return 539;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 100; m_y = 300; m_vy = 0; m_mode = 0;
        m_run = 0; m_atk = 0; m_status = 0; m_face = 0;
    endtask

    task automatic model_step(input logic [7:0] key);
        int dx;
        dx = (key == 8'h04) ? -4 : (key == 8'h07) ? 4 : 0;
        case (m_mode)
            0, 1: begin
                if (key == 8'h0E) begin
                    m_mode = 4; m_atk = 1; m_status = 5;
                end else if (key == 8'h0D) begin
                    m_mode = 3; m_atk = 1; m_status = 3;
                end else if (key == 8'h1A) begin
                    m_mode = 2; m_y = m_y - 12; m_vy = 11; m_status = 0;
                end else if (dx != 0) begin
                    if (m_mode != 1) m_run = 0;
                    m_mode = 1;
                    m_run++;
                    m_x = clampx(m_x + dx);
                    m_face = (dx < 0) ? 1 : 0;
                    m_status = (((m_run - 1) / 6) % 2 == 1) ? 2 : 1;
                end else begin
                    m_mode = 0; m_status = 0;
                end
            end
            2: begin
                m_x = clampx(m_x + dx);
                m_y = m_y - m_vy;
                m_vy--;
                if (m_y >= 300) begin
                    m_y = 300; m_vy = 0; m_mode = 0;
                end
                m_status = 0;
            end
            default: begin
                if (m_atk == 8) begin
                    m_mode = 0; m_atk = 0; m_status = 0;
                end else begin
                    m_atk++;
                    if (m_mode == 4) m_status = (m_atk <= 4) ? 5 : 6;
                    else             m_status = (m_atk <= 4) ? 3 : 4;
                end
            end
        endcase
    endtask

    function automatic int exp_facing();
`ifdef FIGHTER_FACING_EN
        return m_face;
`else
        return 0;
`endif
    endfunction

    // One video frame: key applied, frame_clk pulsed, outputs settled before return.
    task automatic frame(input logic [7:0] key);
        @(negedge Clk);
        bus.keycode = key;
        frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        model_step(key);
        n_frame++;
        $display("frame %0d key=%02h x=%0d y=%0d status=%0d facing=%0b",
                 n_frame, key, bus.positionX, bus.positionY, bus.status, bus.facing);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        bus.keycode = 8'h00;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        #3 Reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.positionX, bus.positionY, bus.status, bus.facing} !== {10'd100, 10'd300, 3'd0, 1'b0})
            $display("FAIL reset: x=%0d y=%0d status=%0d facing=%0b, want 100 300 0 0",
                     bus.positionX, bus.positionY, bus.status, bus.facing);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            frame(8'h00);
            n_checks++;
            if ({bus.positionX, bus.positionY, bus.status} !== {10'd100, 10'd300, 3'd0})
                $display("FAIL idle_frame%0d: x=%0d y=%0d status=%0d, want 100 300 0",
                         i, bus.positionX, bus.positionY, bus.status);
            else n_pass++;
        end
    endtask

    task automatic test_no_tick();
        @(negedge Clk);
        bus.keycode = 8'h07;
        repeat (40) @(negedge Clk);
        n_checks++;
        if ({bus.positionX, bus.status} !== {10'd100, 3'd0})
            $display("FAIL no_tick: x=%0d status=%0d, want 100 0", bus.positionX, bus.status);
        else n_pass++;
    endtask

    task automatic test_run();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            frame(8'h07);
            n_checks++;
            if ({bus.positionX, bus.status} !== {10'(100 + 4 * i), (i <= 6) ? 3'd1 : 3'd2})
                $display("FAIL run_tick%0d: x=%0d status=%0d, want %0d %0d",
                         i, bus.positionX, bus.status, 100 + 4 * i, (i <= 6) ? 1 : 2);
            else n_pass++;
        end
        frame(8'h00);
        n_checks++;
        if ({bus.positionX, bus.status} !== {10'd140, 3'd0})
            $display("FAIL run_release: x=%0d status=%0d, want 140 0", bus.positionX, bus.status);
        else n_pass++;
    endtask

    task automatic test_walls();
        do_reset();
        repeat (24) frame(8'h04);
        n_checks++;
        if (bus.positionX !== 10'd4)
            $display("FAIL left_approach: x=%0d, want 4", bus.positionX);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            frame(8'h04);
            n_checks++;
            if ({bus.positionX, bus.status} === {10'd0, 3'd0} || bus.positionX !== 10'd0)
                $display("FAIL left_wall%0d: x=%0d status=%0d, want 0 and a run pose",
                         i, bus.positionX, bus.status);
            else n_pass++;
        end
        n_checks++;
        if (bus.facing !== 1'(exp_facing()))
            $display("FAIL facing_left: facing=%0b, want %0d", bus.facing, exp_facing());
        else n_pass++;
        repeat (134) frame(8'h07);
        n_checks++;
        if (bus.positionX !== 10'd536)
            $display("FAIL right_approach: x=%0d, want 536", bus.positionX);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            frame(8'h07);
            n_checks++;
            if (bus.positionX !== 10'd539)
                $display("FAIL right_wall%0d: x=%0d, want 539", i, bus.positionX);
            else n_pass++;
        end
    endtask

    task automatic test_jump();
        int ey;
        do_reset();
        for (int n = 1; n <= 25; n++) begin
            frame((n == 1) ? 8'h1A : 8'h00);
            ey = (n == 25) ? 300 : 300 - (12 * n - n * (n - 1) / 2);
            n_checks++;
            if ({bus.positionY, bus.status, bus.positionX} !== {10'(ey), 3'd0, 10'd100})
                $display("FAIL jump_tick%0d: y=%0d status=%0d x=%0d, want %0d 0 100",
                         n, bus.positionY, bus.status, bus.positionX, ey);
            else n_pass++;
        end
        frame(8'h07);
        n_checks++;
        if ({bus.positionY, bus.status, bus.positionX} !== {10'd300, 3'd1, 10'd104})
            $display("FAIL jump_land_idle: y=%0d status=%0d x=%0d, want 300 1 104",
                     bus.positionY, bus.status, bus.positionX);
        else n_pass++;
        do_reset();
        frame(8'h1A);
        for (int n = 2; n <= 25; n++) begin
            frame(8'h07);
            n_checks++;
            if (bus.positionX !== 10'(100 + 4 * (n - 1)))
                $display("FAIL jump_drift%0d: x=%0d, want %0d", n, bus.positionX, 100 + 4 * (n - 1));
            else n_pass++;
        end
        n_checks++;
        if ({bus.positionY, bus.status} !== {10'd300, 3'd0})
            $display("FAIL jump_drift_land: y=%0d status=%0d, want 300 0", bus.positionY, bus.status);
        else n_pass++;
    endtask

    task automatic test_attack(input logic [7:0] key, input logic [2:0] p1, input logic [2:0] p2);
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            frame((n == 1) ? key : (n == 9) ? 8'h00 : 8'h04);
            n_checks++;
            if ({bus.positionX, bus.status} !== {10'd100, (n == 9) ? 3'd0 : (n <= 4) ? p1 : p2})
                $display("FAIL attack%02h_tick%0d: x=%0d status=%0d, want 100 %0d", key, n,
                         bus.positionX, bus.status, (n == 9) ? 0 : (n <= 4) ? p1 : p2);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (8) frame((n_frame % 2 == 0) ? 8'h1A : 8'h07);
        @(negedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.positionX, bus.positionY, bus.status} !== {10'd100, 10'd300, 3'd0})
            $display("FAIL async_reset: x=%0d y=%0d status=%0d, want 100 300 0",
                     bus.positionX, bus.positionY, bus.status);
        else n_pass++;
        repeat (2) @(negedge Clk);
        #5 Reset_n = 1'b1;
        model_reset();
        frame(8'h07);
        n_checks++;
        if ({bus.positionX, bus.status} !== {10'd104, 3'd1})
            $display("FAIL post_reset_run: x=%0d status=%0d, want 104 1", bus.positionX, bus.status);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] keys [7];
        logic [7:0] k;
        keys = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h0D, 8'h0E, 8'h05};
        do_reset();
        for (int i = 0; i < 300; i++) begin
            k = keys[$urandom_range(6, 0)];
            if ($urandom_range(3, 0) != 0 && (k == 8'h0D || k == 8'h0E || k == 8'h1A))
                k = keys[$urandom_range(2, 1)];
            frame(k);
            n_checks++;
            if ({bus.positionX, bus.positionY, bus.status, bus.facing} !==
                {10'(m_x), 10'(m_y), 3'(m_status), 1'(exp_facing())})
                $display("FAIL random%0d: x=%0d y=%0d status=%0d facing=%0b, want %0d %0d %0d %0d",
                         i, bus.positionX, bus.positionY, bus.status, bus.facing,
                         m_x, m_y, m_status, exp_facing());
            else n_pass++;
        end
    endtask

    initial begin
        bus.keycode = 8'h00;
        model_reset();
        test_reset();
        test_no_tick();
        test_run();
        test_walls();
        test_jump();
        test_attack(8'h0E, 3'd5, 3'd6);
        test_attack(8'h0D, 3'd3, 3'd4);
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
